noc_writer: RTL and testbench
=============================

# noc_writer

Injects flits from a show-ahead flit FIFO into a NoC router input port using per-VC credit flow control. It is the transmit counterpart of `noc_reader` and sits at the NoC end of the fabric input port, downstream of the asynchronous FIFO. It tracks downstream buffer space per virtual channel, locks a packet's VC from head to tail, and emits one registered flit per cycle when credit is available.

## Interface
- `WIDTH`, 8: flit width in bits, including control fields.
- `N`, 16: number of NoC nodes.
- `NUM_VC`, 2: number of virtual channels.
- `DEPTH_PER_VC`, 8: downstream buffer depth per VC; this is the initial credit count.
- `ADDRESS_WIDTH`, `$clog2(N)`: destination field width.
- `VC_ADDRESS_WIDTH`, `$clog2(NUM_VC)`: VC field width.

Ports:
- `clk`  in  1  NoC clock (single clock domain).
- `rst`  in  1  asynchronous, active-low reset.
- `i_data_in`  in  WIDTH  flit at the FIFO head (show-ahead).
- `i_empty_in`  in  1  FIFO empty.
- `i_read_en`  out  1  pops the FIFO; combinational.
- `o_flit_out`  out  WIDTH  flit to the router; registered.
- `o_credits_in`  in  NUM_VC  one-cycle pulse per returned credit, per VC.
- `o_err`  out  1  one-cycle pulse when an orphan flit is dropped.
- `o_flit_count`  out  32  flits sent.
- `o_pkt_count`  out  32  tail flits sent.

## Operation
- Flit fields, MSB first:
  - `valid` at bit WIDTH-1.
  - `head` at bit WIDTH-2.
  - `tail` at bit WIDTH-3.
  - `vc` in the VC_ADDRESS_WIDTH bits below `tail`.
  - `dest`, ADDRESS_WIDTH bits.
  - payload in the remaining bits.
- Credit counters: one per VC, each `$clog2(DEPTH_PER_VC+1)` bits wide.
  - Reset to DEPTH_PER_VC.
  - Decrement on a send on that VC; increment on an `o_credits_in[v]` pulse.
  - A send and a credit in the same cycle leave the counter unchanged.
  - A credit arriving while the counter is already at DEPTH_PER_VC is ignored; the counter saturates, and a simulation assertion fires.
- The FSM has two states, `S_IDLE` and `S_PKT`.
- `S_IDLE`:
  - Sends a head flit from the FIFO only if `credit[i_data_in.vc] != 0`.
  - On a head-only send, latches the VC and moves to `S_PKT`.
  - On a head+tail send, stays in `S_IDLE`.
  - A non-head flit with valid set is popped unconditionally, not sent, and pulses `o_err`.
  - A flit with valid clear is popped and discarded without an error.
- `S_PKT`:
  - Sends the next flit on the latched VC when `credit[latched_vc] != 0`.
  - The VC field of the outgoing flit is overwritten with the latched VC.
  - A tail flit returns the FSM to `S_IDLE`.
  - A head flit seen in `S_PKT` is treated as a body flit; there is no error.
- `i_read_en` = `!i_empty_in && (credit ok || orphan/invalid discard)`.
- Any cycle without a send drives `o_flit_out` to all-zero; a valid-clear flit is a bubble.

## Timing
- A flit popped in cycle t appears on `o_flit_out` in cycle t+1, with the credit consumed in t.
- Throughput is one flit per cycle while credit is available; there is no bubble between packets.
- A credit pulse in cycle t is usable for a send decision in cycle t+1.
- From full credit, a VC stalls after DEPTH_PER_VC consecutive sends with no credit return.
- Values held in reset:
  - `o_flit_out` = 0, `o_err` = 0, counts = 0.
  - FSM in `S_IDLE`; credits at DEPTH_PER_VC; `i_read_en` = 0.
- Reset asserted mid-packet abandons the packet. The router side must be reset together with this block.

## Configuration
- `NOC_WRITER_STATS_EN` defined:
  - `o_flit_count` increments per sent flit; `o_pkt_count` increments per sent tail flit.
  - Both are 32-bit and wrap modulo 2^32.
- `NOC_WRITER_STATS_EN` undefined: both ports remain present and are tied to 0. No counter logic is built.

## Structure
- `noc_pkg` holds the flit field position localparams, the `flit_t` packed struct, and the FSM state enum. `noc_reader` uses the same definitions.
- Sub-module `credit_counter` implements one VC counter (init, inc, dec, saturate, assertion). It is instantiated NUM_VC times via generate.

## Test plan
- Single-flit packet on VC1 (head+tail), credits full → `o_flit_out` equals the input flit one cycle after `i_read_en`; credit[1] goes 8→7; `o_pkt_count` = 1 with stats enabled.
- Back-to-back 4-flit packets on VC0 with no credit return → 8 flits sent on consecutive cycles, then `i_read_en` held low. One `o_credits_in[0]` pulse → exactly one more flit, sent one cycle later.
- Body flits carry vc=1 inside a VC0 packet → output VC field = 0 on every flit through the tail.
- Send and credit return on VC0 in the same cycle, repeated for 20 cycles → credit[0] constant; continuous flow with no stall.
- Body flit with valid set while in `S_IDLE` → popped, `o_flit_out` = 0, `o_err` pulses for 1 cycle, and the next head flit sends normally.
- `rst` low for 1 cycle in the middle of a packet → outputs zero immediately, credits return to 8, FSM returns to `S_IDLE`, and a subsequent body flit is dropped with `o_err`.

Source files
------------

// File: rtl/noc_pkg.sv
// noc_pkg: shared flit layout and FSM state definitions for the NoC
// writer/reader pair. Bit offsets are counted down from the flit MSB so they
// hold for any flit width; flit_t describes the default 8-bit, 16-node,
// 2-VC build (which leaves no payload bits).
package noc_pkg;

  // Default build geometry
  localparam int NOC_WIDTH  = 8;
  localparam int NOC_N      = 16;
  localparam int NOC_NUM_VC = 2;
  localparam int NOC_ADDR_W = $clog2(NOC_N);
  localparam int NOC_VC_W   = $clog2(NOC_NUM_VC);

  // Control bit offsets measured from the flit MSB
  localparam int FLIT_VALID_OFS = 0;
  localparam int FLIT_HEAD_OFS  = 1;
  localparam int FLIT_TAIL_OFS  = 2;
  localparam int FLIT_HDR_BITS  = 3;

  // Flit layout for the default build, MSB first
  typedef struct packed {
    logic                  valid;
    logic                  head;
    logic                  tail;
    logic [NOC_VC_W-1:0]   vc;
    logic [NOC_ADDR_W-1:0] dest;
  } flit_t;

  // Packet framing state of the writer
  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_PKT  = 1'b1
  } state_t;

endpackage

// File: rtl/noc_writer_credit_counter.sv
// credit_counter: downstream buffer credits for one virtual channel.
// Starts full, counts down on a send and up on a returned credit. A send and
// a credit in the same cycle cancel. A credit returned while already full is
// ignored (saturating) and flagged by an assertion.
module credit_counter #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic inc_i,
  input  logic dec_i,
  output logic nz_o
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next credit value: cancel, saturating increment, or decrement
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && dec_i) begin
      cnt_d = cnt_q;
    end else if (inc_i) begin
      if (cnt_q != DEPTH_C) begin
        cnt_d = cnt_q + CW'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end else if (dec_i) begin
      cnt_d = cnt_q - CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Credit register, full after reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= DEPTH_C;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign nz_o = (cnt_q != {CW{1'b0}});

  credit_overflow_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(inc_i && !dec_i && (cnt_q == DEPTH_C)))
    else $error("credit_counter: credit returned while counter already full");

  credit_underflow_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(dec_i && !inc_i && (cnt_q == {CW{1'b0}})))
    else $error("credit_counter: send issued with no credit");

endmodule

// File: rtl/noc_writer.sv
// noc_writer: drains a show-ahead flit FIFO into a NoC router input port
// under per-VC credit flow control. A packet's VC is latched at the head and
// forced onto every following flit up to the tail. Output flit is registered;
// FIFO pop is combinational. Orphan (non-head, valid) flits in idle are
// dropped with a one-cycle o_err pulse; invalid flits are silently dropped.
// Optional feature macro: NOC_WRITER_STATS_EN (flit / packet counters).
module noc_writer
  import noc_pkg::*;
#(
  parameter int WIDTH            = 8,
  parameter int N                = 16,
  parameter int NUM_VC           = 2,
  parameter int DEPTH_PER_VC     = 8,
  parameter int ADDRESS_WIDTH    = $clog2(N),
  parameter int VC_ADDRESS_WIDTH = $clog2(NUM_VC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  i_data_in,
  input  logic              i_empty_in,
  output logic              i_read_en,
  output logic [WIDTH-1:0]  o_flit_out,
  input  logic [NUM_VC-1:0] o_credits_in,
  output logic              o_err,
  output logic [31:0]       o_flit_count,
  output logic [31:0]       o_pkt_count
);

  localparam int VALID_BIT = WIDTH - 1 - FLIT_VALID_OFS;
  localparam int HEAD_BIT  = WIDTH - 1 - FLIT_HEAD_OFS;
  localparam int TAIL_BIT  = WIDTH - 1 - FLIT_TAIL_OFS;
  localparam int VC_MSB    = WIDTH - 1 - FLIT_HDR_BITS;
  // dest field plus payload: everything below the VC field
  localparam int REST_W    = ADDRESS_WIDTH + (WIDTH - FLIT_HDR_BITS - VC_ADDRESS_WIDTH - ADDRESS_WIDTH);

  state_t                      state_q;
  state_t                      state_d;
  logic [VC_ADDRESS_WIDTH-1:0] vc_q;
  logic [VC_ADDRESS_WIDTH-1:0] vc_d;
  logic [WIDTH-1:0]            flit_q;
  logic [WIDTH-1:0]            flit_d;
  logic                        err_q;
  logic                        err_d;

  logic                        in_valid_s;
  logic                        in_head_s;
  logic                        in_tail_s;
  logic [VC_ADDRESS_WIDTH-1:0] in_vc_s;
  logic [VC_ADDRESS_WIDTH-1:0] sel_vc_s;
  logic                        credit_ok_s;
  logic                        send_s;
  logic                        pop_s;
  logic [NUM_VC-1:0]           credit_nz_s;
  logic [NUM_VC-1:0]           credit_dec_s;

  assign in_valid_s = i_data_in[VALID_BIT];
  assign in_head_s  = i_data_in[HEAD_BIT];
  assign in_tail_s  = i_data_in[TAIL_BIT];
  assign in_vc_s    = i_data_in[VC_MSB -: VC_ADDRESS_WIDTH];

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    credit_counter #(
      .DEPTH (DEPTH_PER_VC)
    ) u_cnt (
      .clk_i  (clk),
      .rst_ni (rst),
      .inc_i  (o_credits_in[v]),
      .dec_i  (credit_dec_s[v]),
      .nz_o   (credit_nz_s[v])
    );
  end

  // Send/drop decision, next FSM state and next output flit
  always_comb begin
    state_d      = state_q;
    vc_d         = vc_q;
    flit_d       = {WIDTH{1'b0}};
    err_d        = 1'b0;
    send_s       = 1'b0;
    pop_s        = 1'b0;
    sel_vc_s     = (state_q == S_PKT) ? vc_q : in_vc_s;
    credit_ok_s  = credit_nz_s[sel_vc_s];
    if (i_empty_in) begin
      pop_s = 1'b0;
    end else if (!in_valid_s) begin
      // bubble: drop quietly
      pop_s = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!in_head_s) begin
            pop_s = 1'b1;
            err_d = 1'b1;
          end else if (credit_ok_s) begin
            pop_s  = 1'b1;
            send_s = 1'b1;
            flit_d = i_data_in;
            if (!in_tail_s) begin
              state_d = S_PKT;
              vc_d    = in_vc_s;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            pop_s = 1'b0;
          end
        end
        S_PKT: begin
          // a stray head here is carried as a body flit
          if (credit_ok_s) begin
            pop_s  = 1'b1;
            send_s = 1'b1;
            flit_d = {i_data_in[WIDTH-1:VC_MSB+1], vc_q, i_data_in[REST_W-1:0]};
            if (in_tail_s) begin
              state_d = S_IDLE;
            end else begin
              state_d = S_PKT;
            end
          end else begin
            pop_s = 1'b0;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // One-hot credit consumption on the VC being sent
  always_comb begin
    credit_dec_s = {NUM_VC{1'b0}};
    if (send_s) begin
      credit_dec_s[sel_vc_s] = 1'b1;
    end else begin
      credit_dec_s = {NUM_VC{1'b0}};
    end
  end

  assign i_read_en = rst & pop_s;

  // FSM, latched VC, registered flit and error pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      vc_q    <= {VC_ADDRESS_WIDTH{1'b0}};
      flit_q  <= {WIDTH{1'b0}};
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vc_q    <= vc_d;
      flit_q  <= flit_d;
      err_q   <= err_d;
    end
  end

  assign o_flit_out = flit_q;
  assign o_err      = err_q;

`ifdef NOC_WRITER_STATS_EN
  logic [31:0] flit_cnt_q;
  logic [31:0] pkt_cnt_q;

  // Wrapping counts of sent flits and sent tails
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flit_cnt_q <= 32'd0;
      pkt_cnt_q  <= 32'd0;
    end else begin
      if (send_s) begin
        flit_cnt_q <= flit_cnt_q + 32'd1;
      end
      if (send_s && in_tail_s) begin
        pkt_cnt_q <= pkt_cnt_q + 32'd1;
      end
    end
  end

  assign o_flit_count = flit_cnt_q;
  assign o_pkt_count  = pkt_cnt_q;
`else
  assign o_flit_count = 32'd0;
  assign o_pkt_count  = 32'd0;
`endif

endmodule

// File: tb/tb_noc_writer.sv
// Directed self-checking bench for noc_writer (default 8-bit, 2-VC build).
// Flit layout: [7] valid [6] head [5] tail [4] vc [3:0] dest.
module tb_noc_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  i_data_in;
  logic        i_empty_in;
  logic        i_read_en;
  logic [7:0]  o_flit_out;
  logic [1:0]  o_credits_in;
  logic        o_err;
  logic [31:0] o_flit_count;
  logic [31:0] o_pkt_count;

  int          checks   = 0;
  int          failures = 0;
  logic [7:0]  fifo[$];
  logic        rd;

  noc_writer dut (
    .clk          (clk),
    .rst          (rst),
    .i_data_in    (i_data_in),
    .i_empty_in   (i_empty_in),
    .i_read_en    (i_read_en),
    .o_flit_out   (o_flit_out),
    .o_credits_in (o_credits_in),
    .o_err        (o_err),
    .o_flit_count (o_flit_count),
    .o_pkt_count  (o_pkt_count)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mk(input bit v, input bit h, input bit t, input bit vc, input logic [3:0] d);
    return {v, h, t, vc, d};
  endfunction

  // One clock: present FIFO head and credits, capture pop, advance past edge
  task automatic cyc(input logic [1:0] cr);
    i_empty_in   = (fifo.size() == 0);
    i_data_in    = (fifo.size() == 0) ? 8'h00 : fifo[0];
    o_credits_in = cr;
    #1;
    rd = i_read_en;
    @(posedge clk);
    #1;
    if (rd && fifo.size() != 0) void'(fifo.pop_front());
    o_credits_in = 2'b00;
  endtask

  task automatic do_reset();
    fifo.delete();
    i_empty_in   = 1'b1;
    i_data_in    = 8'h00;
    o_credits_in = 2'b00;
    rst = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] exp_cnt;
    exp_cnt = 32'd0;
    rst = 1'b0;
    i_empty_in = 1'b0;
    i_data_in  = mk(1, 1, 1, 0, 4'd1);
    o_credits_in = 2'b00;
    #12;
    checks++; if (i_read_en !== 1'b0) begin failures++; $display("FAIL reset_read_en got=%b exp=0", i_read_en); end
    checks++; if (o_flit_out !== 8'h00) begin failures++; $display("FAIL reset_flit got=%h exp=00", o_flit_out); end
    checks++; if (o_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", o_err); end
    checks++; if (o_flit_count !== exp_cnt) begin failures++; $display("FAIL reset_flit_count got=%0d exp=0", o_flit_count); end
    checks++; if (o_pkt_count !== exp_cnt) begin failures++; $display("FAIL reset_pkt_count got=%0d exp=0", o_pkt_count); end
  endtask

  task automatic test_single_vc1();
    logic [7:0]  f;
    logic [31:0] exp_cnt;
    do_reset();
    f = mk(1, 1, 1, 1, 4'd5);
    fifo.push_back(f);
    cyc(2'b00);
    checks++; if (rd !== 1'b1) begin failures++; $display("FAIL single_read_en got=%b exp=1", rd); end
    checks++; if (o_flit_out !== f) begin failures++; $display("FAIL single_flit got=%h exp=%h", o_flit_out, f); end
    checks++; if (o_err !== 1'b0) begin failures++; $display("FAIL single_err got=%b exp=0", o_err); end
`ifdef NOC_WRITER_STATS_EN
    exp_cnt = 32'd1;
`else
    exp_cnt = 32'd0;
`endif
    checks++; if (o_pkt_count !== exp_cnt) begin failures++; $display("FAIL single_pkt_count got=%0d exp=%0d", o_pkt_count, exp_cnt); end
    checks++; if (o_flit_count !== exp_cnt) begin failures++; $display("FAIL single_flit_count got=%0d exp=%0d", o_flit_count, exp_cnt); end
    cyc(2'b00);
    checks++; if (o_flit_out !== 8'h00) begin failures++; $display("FAIL single_idle_flit got=%h exp=00", o_flit_out); end
    // VC1 now holds 7 credits: exactly 7 of 8 further packets go out
    for (int k = 0; k < 8; k++) fifo.push_back(mk(1, 1, 1, 1, 4'(k)));
    for (int k = 0; k < 8; k++) begin
      f = fifo[0];
      cyc(2'b00);
      checks++; if (rd !== (k < 7)) begin failures++; $display("FAIL vc1_credit_read_en k=%0d got=%b exp=%b", k, rd, (k < 7)); end
      checks++; if (o_flit_out !== ((k < 7) ? f : 8'h00)) begin failures++; $display("FAIL vc1_credit_flit k=%0d got=%h", k, o_flit_out); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] inp [9];
    logic [7:0] exp [8];
    inp = '{mk(1,1,0,0,4'd3), mk(1,0,0,0,4'd4), mk(1,0,0,0,4'd5), mk(1,0,1,0,4'd6),
            mk(1,1,0,0,4'd7), mk(1,0,0,1,4'd8), mk(1,0,0,1,4'd9), mk(1,0,1,1,4'd10),
            mk(1,1,1,0,4'd11)};
    exp = '{mk(1,1,0,0,4'd3), mk(1,0,0,0,4'd4), mk(1,0,0,0,4'd5), mk(1,0,1,0,4'd6),
            mk(1,1,0,0,4'd7), mk(1,0,0,0,4'd8), mk(1,0,0,0,4'd9), mk(1,0,1,0,4'd10)};
    do_reset();
    for (int k = 0; k < 9; k++) fifo.push_back(inp[k]);
    for (int k = 0; k < 8; k++) begin
      cyc(2'b00);
      checks++; if (rd !== 1'b1) begin failures++; $display("FAIL b2b_read_en k=%0d got=%b exp=1", k, rd); end
      checks++; if (o_flit_out !== exp[k]) begin failures++; $display("FAIL b2b_flit k=%0d got=%h exp=%h", k, o_flit_out, exp[k]); end
    end
    for (int k = 0; k < 2; k++) begin
      cyc(2'b00);
      checks++; if (rd !== 1'b0) begin failures++; $display("FAIL b2b_stall k=%0d got=%b exp=0", k, rd); end
      checks++; if (o_flit_out !== 8'h00) begin failures++; $display("FAIL b2b_stall_flit k=%0d got=%h exp=00", k, o_flit_out); end
    end
    cyc(2'b01);
    checks++; if (rd !== 1'b0) begin failures++; $display("FAIL credit_latency got=%b exp=0", rd); end
    cyc(2'b00);
    checks++; if (rd !== 1'b1) begin failures++; $display("FAIL credit_reuse_read_en got=%b exp=1", rd); end
    checks++; if (o_flit_out !== inp[8]) begin failures++; $display("FAIL credit_reuse_flit got=%h exp=%h", o_flit_out, inp[8]); end
    cyc(2'b00);
    checks++; if (o_flit_out !== 8'h00) begin failures++; $display("FAIL credit_reuse_after got=%h exp=00", o_flit_out); end
  endtask

  task automatic test_same_cycle_credit();
    logic [7:0] f;
    do_reset();
    for (int k = 0; k < 20; k++) fifo.push_back(mk(1, 1, 1, 0, 4'(k)));
    for (int k = 0; k < 20; k++) begin
      f = fifo[0];
      cyc(2'b01);
      checks++; if (rd !== 1'b1 || o_flit_out !== f) begin failures++; $display("FAIL same_cycle k=%0d rd=%b got=%h exp=%h", k, rd, o_flit_out, f); end
    end
    // credit still full: 8 more sends, then a stall
    for (int k = 0; k < 9; k++) fifo.push_back(mk(1, 1, 1, 0, 4'(k)));
    for (int k = 0; k < 9; k++) begin
      cyc(2'b00);
      checks++; if (rd !== (k < 8)) begin failures++; $display("FAIL same_cycle_credit_left k=%0d got=%b exp=%b", k, rd, (k < 8)); end
    end
  endtask

  task automatic test_orphan();
    logic [7:0] f;
    do_reset();
    f = mk(1, 1, 1, 0, 4'd2);
    fifo.push_back(mk(1, 0, 0, 0, 4'd3));
    fifo.push_back(f);
    fifo.push_back(mk(0, 1, 1, 0, 4'd1));
    cyc(2'b00);
    checks++; if (rd !== 1'b1) begin failures++; $display("FAIL orphan_pop got=%b exp=1", rd); end
    checks++; if (o_flit_out !== 8'h00) begin failures++; $display("FAIL orphan_flit got=%h exp=00", o_flit_out); end
    checks++; if (o_err !== 1'b1) begin failures++; $display("FAIL orphan_err got=%b exp=1", o_err); end
    cyc(2'b00);
    checks++; if (o_flit_out !== f) begin failures++; $display("FAIL orphan_next_flit got=%h exp=%h", o_flit_out, f); end
    checks++; if (o_err !== 1'b0) begin failures++; $display("FAIL orphan_err_width got=%b exp=0", o_err); end
    cyc(2'b00);
    checks++; if (rd !== 1'b1) begin failures++; $display("FAIL bubble_pop got=%b exp=1", rd); end
    checks++; if (o_flit_out !== 8'h00 || o_err !== 1'b0) begin failures++; $display("FAIL bubble flit=%h err=%b exp 00/0", o_flit_out, o_err); end
  endtask

  task automatic test_reset_mid_packet();
    logic [7:0] f;
    do_reset();
    f = mk(1, 1, 0, 1, 4'd2);
    fifo.push_back(f);
    fifo.push_back(mk(1, 0, 0, 1, 4'd3));
    cyc(2'b00);
    checks++; if (o_flit_out !== f) begin failures++; $display("FAIL midrst_head got=%h exp=%h", o_flit_out, f); end
    i_empty_in = 1'b0;
    i_data_in  = fifo[0];
    rst = 1'b0;
    #1;
    checks++; if (o_flit_out !== 8'h00) begin failures++; $display("FAIL midrst_flit got=%h exp=00", o_flit_out); end
    checks++; if (i_read_en !== 1'b0) begin failures++; $display("FAIL midrst_read_en got=%b exp=0", i_read_en); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc(2'b00);
    checks++; if (rd !== 1'b1 || o_flit_out !== 8'h00) begin failures++; $display("FAIL midrst_body rd=%b flit=%h exp 1/00", rd, o_flit_out); end
    checks++; if (o_err !== 1'b1) begin failures++; $display("FAIL midrst_err got=%b exp=1", o_err); end
    // VC1 credits restored to 8
    for (int k = 0; k < 9; k++) fifo.push_back(mk(1, 1, 1, 1, 4'(k)));
    for (int k = 0; k < 9; k++) begin
      cyc(2'b00);
      checks++; if (rd !== (k < 8)) begin failures++; $display("FAIL midrst_credit k=%0d got=%b exp=%b", k, rd, (k < 8)); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_vc1();
    test_back_to_back();
    test_same_cycle_credit();
    test_orphan();
    test_reset_mid_packet();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
